// File: rtl/line_sensor_processor.sv
// Line-sensor front end: re-times three ADC readings into clk_50M, averages them over
// four samples, thresholds with hysteresis and tracks follow/node/lost for motion control.
module line_sensor_processor #(
  parameter logic [11:0] THRESH_HI    = 12'd700,
  parameter logic [11:0] THRESH_LO    = 12'd500,
  parameter int unsigned NODE_CONFIRM = 3,
  parameter int unsigned LOST_CONFIRM = 8
) (
  input  logic        clk_50M,
  input  logic        rst_n,
  input  logic        sample_tick,
  input  logic        enable,
  input  logic [11:0] left_value,
  input  logic [11:0] center_value,
  input  logic [11:0] right_value,
  output logic [11:0] filt_left,
  output logic [11:0] filt_center,
  output logic [11:0] filt_right,
  output logic [2:0]  line_bits,
  output logic        bits_valid,
  output logic [1:0]  fsm_state,
  output logic        node_pulse,
  output logic [7:0]  node_count,
  output logic        lost
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FOLLOW = 2'd1,
    NODE   = 2'd2,
    LOST   = 2'd3
  } state_t;

  localparam logic [3:0] NODE_N = 4'(NODE_CONFIRM);
  localparam logic [3:0] LOST_N = 4'(LOST_CONFIRM);

  // Channel index 0 = left, 1 = center, 2 = right throughout.
  logic [11:0] raw [3];
  assign raw[0] = left_value;
  assign raw[1] = center_value;
  assign raw[2] = right_value;

  logic [11:0] sync1_q [3];
  logic [11:0] sync2_q [3];
  logic [11:0] sync3_q [3];

  logic        pending_q, pending_d;
  logic        stable, accept;
  logic [11:0] hist_q [3][4];
  logic [11:0] hist_d [3][4];
  logic [13:0] sum_q [3];
  logic [13:0] sum_d [3];
  logic [2:0]  warm_q, warm_d;
  logic        upd_q, upd_d;
  logic        on_q [3];
  logic        on_d [3];
  logic        valid_q, valid_d;
  state_t      state_q, state_d;
  logic [3:0]  node_cnt_q, node_cnt_d;
  logic [3:0]  lost_cnt_q, lost_cnt_d;
  logic [7:0]  count_q, count_d;
  logic        pulse_q, pulse_d;
  logic        lost_q, lost_d;
  logic [2:0]  bits;

  assign bits = {on_q[0], on_q[1], on_q[2]};

  // NOTE: sequential state uses <= so every flop samples pre-edge values regardless of
  // statement order; blocking assignments here would chain the synchroniser stages.
  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) begin
        sync1_q[i[1:0]] <= '0;
        sync2_q[i[1:0]] <= '0;
        sync3_q[i[1:0]] <= '0;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        sync1_q[i[1:0]] <= raw[i[1:0]];
        sync2_q[i[1:0]] <= sync1_q[i[1:0]];
        sync3_q[i[1:0]] <= sync2_q[i[1:0]];
      end
    end
  end

  always_comb begin
    // NOTE: every _d starts from its _q (or a strobe default) so no path leaves a
    // variable unassigned, which would otherwise infer a latch.
    pending_d  = pending_q;
    hist_d     = hist_q;
    sum_d      = sum_q;
    warm_d     = warm_q;
    on_d       = on_q;
    valid_d    = 1'b0;
    state_d    = state_q;
    node_cnt_d = node_cnt_q;
    lost_cnt_d = lost_cnt_q;
    count_d    = count_q;
    lost_d     = lost_q;
    pulse_d    = 1'b0;

    // A value still changing between sync stages was caught mid-update; wait it out.
    stable = (sync2_q[0] == sync3_q[0]) && (sync2_q[1] == sync3_q[1]) &&
             (sync2_q[2] == sync3_q[2]);
    accept    = pending_q && stable;
    pending_d = sample_tick || (pending_q && !accept);
    upd_d     = accept;

    if (accept) begin
      for (int i = 0; i < 3; i++) begin
        sum_d[i[1:0]]     = sum_q[i[1:0]] + 14'(sync2_q[i[1:0]]) - 14'(hist_q[i[1:0]][3]);
        hist_d[i[1:0]][3] = hist_q[i[1:0]][2];
        hist_d[i[1:0]][2] = hist_q[i[1:0]][1];
        hist_d[i[1:0]][1] = hist_q[i[1:0]][0];
        hist_d[i[1:0]][0] = sync2_q[i[1:0]];
      end
      warm_d = (warm_q == 3'd4) ? 3'd4 : warm_q + 3'd1;
    end

    if (upd_q) begin
      for (int i = 0; i < 3; i++) begin
        if (sum_q[i[1:0]][13:2] > THRESH_HI)      on_d[i[1:0]] = 1'b1;
        else if (sum_q[i[1:0]][13:2] < THRESH_LO) on_d[i[1:0]] = 1'b0;
      end
      valid_d = (warm_q == 3'd4);
    end

    if (!enable) begin
      state_d    = IDLE;
      node_cnt_d = '0;
      lost_cnt_d = '0;
      lost_d     = 1'b0;
    end else if (valid_q) begin
      case (state_q)
        IDLE: begin
          state_d    = FOLLOW;
          node_cnt_d = '0;
          lost_cnt_d = '0;
        end
        FOLLOW: begin
          node_cnt_d = '0;
          lost_cnt_d = '0;
          if (bits == 3'b111) begin
            if (node_cnt_q + 4'd1 == NODE_N) begin
              state_d = NODE;
              pulse_d = 1'b1;
              count_d = count_q + 8'd1;
            end else begin
              node_cnt_d = node_cnt_q + 4'd1;
            end
          end else if (bits == 3'b000) begin
            if (lost_cnt_q + 4'd1 == LOST_N) begin
              state_d = LOST;
              lost_d  = 1'b1;
            end else begin
              lost_cnt_d = lost_cnt_q + 4'd1;
            end
          end
        end
        NODE: begin
          if (bits != 3'b111) begin
            state_d    = FOLLOW;
            node_cnt_d = '0;
            lost_cnt_d = (bits == 3'b000) ? 4'd1 : 4'd0;
          end
        end
        LOST: begin
          if (bits != 3'b000) begin
            state_d    = FOLLOW;
            lost_d     = 1'b0;
            node_cnt_d = '0;
            lost_cnt_d = '0;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      pending_q <= 1'b0;
      // NOTE: the history is reset along with everything else so a reset restarts the
      // average from zero and the warm-up period is meaningful.
      for (int i = 0; i < 3; i++) begin
        for (int k = 0; k < 4; k++) hist_q[i[1:0]][k[1:0]] <= '0;
        sum_q[i[1:0]] <= '0;
        on_q[i[1:0]]  <= 1'b0;
      end
      warm_q     <= '0;
      upd_q      <= 1'b0;
      valid_q    <= 1'b0;
      state_q    <= IDLE;
      node_cnt_q <= '0;
      lost_cnt_q <= '0;
      count_q    <= '0;
      pulse_q    <= 1'b0;
      lost_q     <= 1'b0;
    end else begin
      pending_q  <= pending_d;
      hist_q     <= hist_d;
      sum_q      <= sum_d;
      on_q       <= on_d;
      warm_q     <= warm_d;
      upd_q      <= upd_d;
      valid_q    <= valid_d;
      state_q    <= state_d;
      node_cnt_q <= node_cnt_d;
      lost_cnt_q <= lost_cnt_d;
      count_q    <= count_d;
      pulse_q    <= pulse_d;
      lost_q     <= lost_d;
    end
  end

  assign filt_left   = sum_q[0][13:2];
  assign filt_center = sum_q[1][13:2];
  assign filt_right  = sum_q[2][13:2];
  assign line_bits   = bits;
  assign bits_valid  = valid_q;
  assign fsm_state   = state_q;
  assign node_pulse  = pulse_q;
  assign node_count  = count_q;
  assign lost        = lost_q;

endmodule

// File: tb/tb_line_sensor_processor.sv
// Directed bench for line_sensor_processor: a behavioural model predicts each valid sample
// into a scoreboard queue; a negedge monitor pops and compares when the DUT strobes.
module tb_line_sensor_processor;

  logic        clk_50M = 1'b0;
  logic        rst_n = 1'b0;
  logic        sample_tick = 1'b0;
  logic        enable = 1'b0;
  logic [11:0] left_value = '0, center_value = '0, right_value = '0;
  logic [11:0] filt_left, filt_center, filt_right;
  logic [2:0]  line_bits;
  logic        bits_valid;
  logic [1:0]  fsm_state;
  logic        node_pulse;
  logic [7:0]  node_count;
  logic        lost;

  line_sensor_processor dut (
    .clk_50M(clk_50M), .rst_n(rst_n), .sample_tick(sample_tick), .enable(enable),
    .left_value(left_value), .center_value(center_value), .right_value(right_value),
    .filt_left(filt_left), .filt_center(filt_center), .filt_right(filt_right),
    .line_bits(line_bits), .bits_valid(bits_valid), .fsm_state(fsm_state),
    .node_pulse(node_pulse), .node_count(node_count), .lost(lost)
  );

  always #10 clk_50M = ~clk_50M;

  typedef struct {
    logic [11:0] fl, fc, fr;
    logic [2:0]  bits;
    logic [1:0]  st;
    logic [7:0]  cnt;
    logic        lst;
    logic        pulse;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;

  // Behavioural model state
  int mh[3][4];
  int mwarm, mstate, mnc, mlc, mcount;
  bit mon[3];
  bit mlost;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  function automatic void model_reset();
    for (int c = 0; c < 3; c++) begin
      for (int k = 0; k < 4; k++) mh[c][k] = 0;
      mon[c] = 1'b0;
    end
    mwarm = 0; mstate = 0; mnc = 0; mlc = 0; mcount = 0; mlost = 1'b0;
  endfunction

  function automatic void model_sample(input int l, input int c, input int r);
    int   v[3];
    int   f[3];
    int   s;
    bit   pulse;
    logic [2:0] b;
    exp_t e;
    v[0] = l; v[1] = c; v[2] = r;
    for (int ch = 0; ch < 3; ch++) begin
      for (int k = 3; k > 0; k--) mh[ch][k] = mh[ch][k-1];
      mh[ch][0] = v[ch];
      s = mh[ch][0] + mh[ch][1] + mh[ch][2] + mh[ch][3];
      f[ch] = s / 4;
      if (f[ch] > 700) mon[ch] = 1'b1;
      else if (f[ch] < 500) mon[ch] = 1'b0;
    end
    mwarm = (mwarm < 4) ? mwarm + 1 : 4;
    if (mwarm < 4) return;
    b = {mon[0], mon[1], mon[2]};
    pulse = 1'b0;
    case (mstate)
      0: begin mstate = 1; mnc = 0; mlc = 0; end
      1: begin
        if (b == 3'b111) begin
          mnc++; mlc = 0;
          if (mnc == 3) begin mstate = 2; pulse = 1'b1; mcount = (mcount + 1) % 256; mnc = 0; end
        end else if (b == 3'b000) begin
          mlc++; mnc = 0;
          if (mlc == 8) begin mstate = 3; mlost = 1'b1; mlc = 0; end
        end else begin
          mnc = 0; mlc = 0;
        end
      end
      2: if (b != 3'b111) begin mstate = 1; mnc = 0; mlc = (b == 3'b000) ? 1 : 0; end
      default: if (b != 3'b000) begin mstate = 1; mlost = 1'b0; mnc = 0; mlc = 0; end
    endcase
    e.fl = 12'(f[0]); e.fc = 12'(f[1]); e.fr = 12'(f[2]);
    e.bits = b; e.st = 2'(mstate); e.cnt = 8'(mcount); e.lst = mlost; e.pulse = pulse;
    sb.push_back(e);
  endfunction

  // Monitor: compares filter/threshold on the strobe, FSM outputs one clock later.
  exp_t cur;
  bit   fsm_chk = 1'b0;
  always @(negedge clk_50M) begin
    if (!rst_n) begin
      fsm_chk = 1'b0;
    end else begin
      if (fsm_chk) begin
        check("fsm_state", fsm_state, cur.st);
        check("node_pulse", node_pulse, cur.pulse);
        check("node_count", node_count, cur.cnt);
        check("lost", lost, cur.lst);
        fsm_chk = 1'b0;
      end else begin
        check("pulse_quiet", node_pulse, 1'b0);
      end
      if (bits_valid) begin
        if (sb.size() == 0) begin
          check("spurious_valid", bits_valid, 1'b0);
        end else begin
          cur = sb.pop_front();
          check("filt_left", filt_left, cur.fl);
          check("filt_center", filt_center, cur.fc);
          check("filt_right", filt_right, cur.fr);
          check("line_bits", line_bits, cur.bits);
          fsm_chk = 1'b1;
        end
      end
    end
  end

  task automatic apply(input int l, input int c, input int r);
    left_value = 12'(l); center_value = 12'(c); right_value = 12'(r);
    repeat (4) @(posedge clk_50M);
    #1;
    model_sample(l, c, r);
    sample_tick = 1'b1;
    @(posedge clk_50M); #1;
    sample_tick = 1'b0;
    repeat (4) @(posedge clk_50M);
    #1;
  endtask

  task automatic toggle_center(input int n);
    repeat (n) begin
      center_value = (center_value == 12'd4000) ? 12'd0 : 12'd4000;
      @(posedge clk_50M); #1;
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_fl"}, filt_left, 0);
    check({tag, "_fc"}, filt_center, 0);
    check({tag, "_fr"}, filt_right, 0);
    check({tag, "_bits"}, line_bits, 0);
    check({tag, "_valid"}, bits_valid, 0);
    check({tag, "_state"}, fsm_state, 0);
    check({tag, "_pulse"}, node_pulse, 0);
    check({tag, "_count"}, node_count, 0);
    check({tag, "_lost"}, lost, 0);
  endtask

  initial begin
    int lat;
    bit seen;
    model_reset();

    // Reset state
    #5;
    check_all_zero("reset");
    @(posedge clk_50M); #1;
    rst_n = 1'b1;
    enable = 1'b1;
    @(posedge clk_50M); #1;

    // Warm-up with L/C/R = 0/1000/0; the 4th sample is timed tick -> strobe
    repeat (3) apply(0, 1000, 0);
    check("warmup_no_valid", sb.size(), 0);
    repeat (4) @(posedge clk_50M);
    #1;
    model_sample(0, 1000, 0);
    sample_tick = 1'b1;
    @(posedge clk_50M); #1;
    sample_tick = 1'b0;
    lat = 1; seen = 1'b0;
    while (!seen && lat < 8) begin
      @(negedge clk_50M);
      if (bits_valid) seen = 1'b1;
      else begin @(posedge clk_50M); lat++; end
    end
    check("t1_latency", lat, 3);
    check("t1_filt_c", filt_center, 1000);
    check("t1_bits", line_bits, 3'b010);
    repeat (3) @(posedge clk_50M);
    #1;
    check("t1_follow", fsm_state, 1);

    // Unstable center during the tick: the accept must wait for the frozen value
    toggle_center(3);
    model_sample(0, 2000, 0);
    sample_tick = 1'b1;
    toggle_center(1);
    sample_tick = 1'b0;
    toggle_center(6);
    center_value = 12'd2000;
    repeat (8) @(posedge clk_50M);
    #1;
    check("glitch_drain", sb.size(), 0);
    check("glitch_filt_c", filt_center, 1250);

    // Hysteresis on center: 1150,1050,950,600 -> 450,300,150,0 -> 200,400,600,800
    repeat (4) apply(0, 600, 0);
    check("hyst_600_filt", filt_center, 600);
    check("hyst_600_bit", line_bits[1], 1'b1);
    apply(0, 0, 0);
    check("hyst_450_filt", filt_center, 450);
    check("hyst_450_bit", line_bits[1], 1'b0);
    repeat (3) apply(0, 0, 0);
    repeat (3) apply(0, 800, 0);
    check("hyst_600up_bit", line_bits[1], 1'b0);
    apply(0, 800, 0);
    check("hyst_800_bit", line_bits[1], 1'b1);

    // Node detection, no re-pulse while held, exit on 010
    repeat (3) apply(4000, 4000, 4000);
    check("node_state", fsm_state, 2);
    check("node_count1", node_count, 1);
    apply(4000, 4000, 4000);
    check("node_hold", fsm_state, 2);
    repeat (4) apply(0, 4000, 0);
    check("node_exit", fsm_state, 1);

    // Lost after 8 valid 000 samples, recovery on center
    repeat (11) apply(0, 0, 0);
    check("lost_state", fsm_state, 3);
    check("lost_flag", lost, 1'b1);
    apply(0, 4000, 0);
    check("recover_state", fsm_state, 1);
    check("recover_lost", lost, 1'b0);

    // Run nodes until node_count wraps 255 -> 0
    while (mcount != 255) begin
      repeat (3) apply(4000, 4000, 4000);
      repeat (4) apply(0, 4000, 0);
    end
    check("count_255", node_count, 255);
    repeat (3) apply(4000, 4000, 4000);
    check("count_wrap", node_count, 0);
    repeat (4) apply(0, 4000, 0);

    // enable=0 forces IDLE
    enable = 1'b0;
    repeat (2) @(posedge clk_50M);
    #1;
    check("disable_state", fsm_state, 0);
    check("disable_lost", lost, 1'b0);
    mstate = 0; mnc = 0; mlc = 0; mlost = 1'b0;
    enable = 1'b1;
    apply(0, 4000, 0);
    check("reenable_state", fsm_state, 1);

    // Reset with a tick pending behind unstable input
    toggle_center(3);
    sample_tick = 1'b1;
    toggle_center(1);
    sample_tick = 1'b0;
    toggle_center(1);
    #4 rst_n = 1'b0;
    #1;
    check_all_zero("midrst");
    sb.delete();
    model_reset();
    center_value = 12'd1000;
    repeat (3) @(posedge clk_50M);
    #1;
    rst_n = 1'b1;
    repeat (3) apply(0, 1000, 0);
    check("midrst_no_valid", sb.size(), 0);
    check("midrst_idle", fsm_state, 0);
    apply(0, 1000, 0);
    check("midrst_drain", sb.size(), 0);
    check("midrst_filt_c", filt_center, 1000);
    check("midrst_follow", fsm_state, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/line_sensor_processor.md
Name: line_sensor_processor

Overview:
- Consumes the three 12-bit line-sensor readings (left/center/right) produced by the ADC controller and re-times them into the clk_50M domain.
- Rejects values caught mid-update and filters each channel with a 4-tap moving average.
- Thresholds each channel with hysteresis into on-line bits.
- Runs a follow/node/lost state machine whose outputs feed the motion controller.

Parameters:
- THRESH_HI, 12'd700, filtered value strictly above this sets the channel bit to 1 (on black line).
- THRESH_LO, 12'd500, filtered value strictly below this clears the channel bit; values in between hold the bit. Must be ≤ THRESH_HI.
- NODE_CONFIRM, 3, consecutive valid 3'b111 samples needed to declare a node (range 1..15).
- LOST_CONFIRM, 8, consecutive valid 3'b000 samples needed to declare line lost (range 1..15).

Ports:
- clk_50M  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- sample_tick  input  1  one-clk request to take a sample
- enable  input  1  run FSM; 0 forces IDLE
- left_value  input  12  raw ADC reading, adc_sck domain
- center_value  input  12  raw ADC reading, adc_sck domain
- right_value  input  12  raw ADC reading, adc_sck domain
- filt_left  output  12  filtered left
- filt_center  output  12  filtered center
- filt_right  output  12  filtered right
- line_bits  output  3  {L,C,R} on-line flags
- bits_valid  output  1  one-clk strobe: new line_bits
- fsm_state  output  2  0=IDLE 1=FOLLOW 2=NODE 3=LOST
- node_pulse  output  1  one-clk strobe on node entry
- node_count  output  8  nodes detected, wraps 255→0
- lost  output  1  high while in LOST

Behaviour:
- Reset (async, rst_n=0): all registers, history, counters and outputs are 0; fsm_state=IDLE; warm-up count=0.
- Input re-timing:
  - Each input bit passes through a 2-flop synchroniser (sync2), plus a third register (sync3) holding the previous cycle.
  - A channel is stable when sync2==sync3.
- Capture:
  - sample_tick sets a single pending flag; ticks arriving while pending are merged, not queued.
  - The sample is accepted in the first cycle where pending=1 and all three channels are stable. That cycle clears pending, unless a new tick arrives in the same cycle, in which case pending remains 1.
- Filter (accept cycle A, registered at A+1):
  - 4-entry history per channel, shift in newest.
  - 14-bit running sum; filt_x = sum[13:2], truncating.
  - Warm-up counter saturates at 4; the first 3 accepted samples update the filter but produce no bits_valid.
- Threshold (registered at A+2):
  - per channel: bit=1 if filt>THRESH_HI, bit=0 if filt<THRESH_LO, else bit holds.
  - bits_valid=1 for exactly that cycle, only once warm-up reaches 4.
- FSM (updates at A+3, only on bits_valid cycles):
  - enable=0: IDLE from any state; node/lost counters cleared; lost=0; node_count holds.
  - IDLE→FOLLOW on the first bits_valid with enable=1. That sample is not counted.
  - FOLLOW:
    - 111 increments node_cnt and clears lost_cnt.
    - 000 increments lost_cnt and clears node_cnt.
    - Any other pattern clears both counters.
    - node_cnt reaching NODE_CONFIRM → NODE, node_pulse=1 for one clk, node_count+1.
    - lost_cnt reaching LOST_CONFIRM → LOST, lost=1.
  - NODE:
    - Stays while 111.
    - Non-111 → FOLLOW with counters cleared; if that sample is 000, lost_cnt=1.
  - LOST: any non-000 → FOLLOW, lost=0, counters cleared.
- Latency: accept→bits_valid = 2 clk; accept→fsm_state/node_pulse = 3 clk.
- Reset mid-operation discards pending, history and warm-up; the next valid output needs 4 fresh samples.

Test Plan:
- Reset, enable=1, hold L/C/R=0/1000/0, 4 ticks → bits_valid once, 2 clk after the 4th accept; filt_center=1000; line_bits=3'b010; fsm_state=FOLLOW.
- Toggle center_value every clk during a tick, then freeze it → accept is delayed until 2 equal sync cycles; no bits_valid before that; filt values match the frozen value.
- Warm-up done, center filtered 600, prior bit=1 → bit stays 1. Drop raw to 0 → filt steps 450 (bit=0), then 300, 150, 0, bit stays 0. Raise to 800 → filt must exceed 700 before bit=1.
- FOLLOW, all channels 4000 for 3 valid samples → node_pulse exactly once, node_count 0→1, state NODE. 4th 111 sample → no new pulse. Then 3'b010 → FOLLOW.
- All channels 0 for 8 valid samples → LOST, lost=1. Then center 4000 (filtered >700) → FOLLOW, lost=0. Preload node_count=255 and detect a node → count reads 0.
- Assert rst_n=0 mid-sequence with pending tick → all outputs 0 immediately. After release, 3 ticks give no bits_valid; the 4th does.
